// File: rtl/demux_pkg.sv
// Shared widths, channel count, serializer state encoding and select-width helper
// for the word-to-packet demultiplexer.
package demux_pkg;

  localparam int DEF_MST_DWIDTH = 32;
  localparam int DEF_SYS_DWIDTH = 8;
  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } demux_state_t;

  // A single channel still needs one select bit on the port.
  function automatic int sel_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data is always the head entry, and pop consumes it.
// Push while full and pop while empty are ignored.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_mst,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_mst) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_mst) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/packet_demux.sv
// Buffers {sel, word} pairs and serializes each word LSB slice first onto the
// selected output channel with a valid/ready handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no word in flight; pops head (forwards or discards bad sel)
// ST_SEND | presenting packet cnt of word on channel sel
module packet_demux
  import demux_pkg::*;
#(
  parameter int  MST_DWIDTH = DEF_MST_DWIDTH,
  parameter int  SYS_DWIDTH = DEF_SYS_DWIDTH,
  parameter int  NUM_CH     = DEF_NUM_CH,
  parameter int  FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int SEL_W      = sel_width(NUM_CH),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk_mst,
  input  logic                         rst_n,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic [SEL_W-1:0]             sel_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  output logic [NUM_CH-1:0]            last_o,
  input  logic [NUM_CH-1:0]            ready_i,
  output logic                         err_o,
  output logic [LVL_W-1:0]             level_o
);

  localparam int RATIO = MST_DWIDTH / SYS_DWIDTH;
  localparam int CNT_W = $clog2(RATIO);
  localparam int FW    = SEL_W + MST_DWIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic                  ready_en;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_rd;
  logic                  push;
  logic                  pop;
  logic [SEL_W-1:0]      head_sel;
  logic [MST_DWIDTH-1:0] head_data;
  logic                  head_ok;

  demux_state_t          state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [MST_DWIDTH-1:0] word;
  logic [SEL_W-1:0]      sel;
  logic                  hs;
  logic                  at_last;
  logic                  take_head;

  function automatic logic [NUM_CH-1:0] ch_mask(input logic [SEL_W-1:0] s);
    ch_mask = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (int'(s) == k) ch_mask[k] = 1'b1;
  endfunction

  function automatic logic [NUM_CH*SYS_DWIDTH-1:0] place(
    input logic [MST_DWIDTH-1:0] w,
    input logic [CNT_W-1:0]      idx,
    input logic [SEL_W-1:0]      s
  );
    logic [MST_DWIDTH-1:0] sh;
    sh    = w >> (int'(idx) * SYS_DWIDTH);
    place = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (int'(s) == k) place[k*SYS_DWIDTH +: SYS_DWIDTH] = sh[SYS_DWIDTH-1:0];
  endfunction

  // ready_o depends on occupancy only, so a pop never frees a slot in the same cycle.
  assign ready_o = ready_en & ~fifo_full;
  assign push    = valid_i & ready_o;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_mst (clk_mst),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({sel_i, data_i}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level_o)
  );

  assign {head_sel, head_data} = fifo_rd;
  assign head_ok   = ~fifo_empty && (int'(head_sel) < NUM_CH);
  assign hs        = (state == ST_SEND) && ready_i[sel];
  assign at_last   = (cnt == CNT_LAST);
  assign cnt_nxt   = cnt + 1'b1;
  assign take_head = ((state == ST_IDLE) && ~fifo_empty) || (hs && at_last);

  always_comb begin
    pop = 1'b0;
    if (take_head) pop = ~fifo_empty;
  end

  always_ff @(posedge clk_mst) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      word     <= '0;
      sel      <= '0;
      data_o   <= '0;
      valid_o  <= '0;
      last_o   <= '0;
      err_o    <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      err_o    <= 1'b0;
      if (take_head) begin
        if (head_ok) begin
          // Chaining here on the last handshake gives back-to-back words with no bubble.
          state   <= ST_SEND;
          cnt     <= '0;
          word    <= head_data;
          sel     <= head_sel;
          data_o  <= place(head_data, '0, head_sel);
          valid_o <= ch_mask(head_sel);
          last_o  <= '0;
        end else begin
          state   <= ST_IDLE;
          data_o  <= '0;
          valid_o <= '0;
          last_o  <= '0;
          err_o   <= ~fifo_empty;
        end
      end else if (hs) begin
        cnt    <= cnt_nxt;
        data_o <= place(word, cnt_nxt, sel);
        last_o <= (cnt_nxt == CNT_LAST) ? ch_mask(sel) : '0;
      end
    end
  end

endmodule

// File: tb/tb_packet_demux.sv
// Cycle-table bench for packet_demux with default parameters, plus a handshake
// sequence with a toggling downstream ready.
module tb_packet_demux;

  logic        clk_mst = 1'b0;
  logic        rst_n;
  logic [31:0] data_i;
  logic [1:0]  sel_i;
  logic        valid_i;
  logic        ready_o;
  logic [23:0] data_o;
  logic [2:0]  valid_o;
  logic [2:0]  last_o;
  logic [2:0]  ready_i;
  logic        err_o;
  logic [2:0]  level_o;

  always #5 clk_mst = ~clk_mst;

  packet_demux dut (
    .clk_mst (clk_mst),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .sel_i   (sel_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .last_o  (last_o),
    .ready_i (ready_i),
    .err_o   (err_o),
    .level_o (level_o)
  );

  // One row per cycle: inputs driven for the coming edge, outputs expected now.
  typedef struct {
    logic        rst;
    logic        v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [2:0]  rdy;
    logic        er;
    logic [2:0]  evo;
    logic [2:0]  elo;
    logic [23:0] edo;
    logic        eerr;
    logic [2:0]  elvl;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input int rst, input int v, input int sel, input logic [31:0] d,
                     input int rdy, input int er, input int evo, input int elo,
                     input int edo, input int eerr, input int elvl);
    vec_t t;
    t.rst  = 1'(rst);
    t.v    = 1'(v);
    t.sel  = 2'(sel);
    t.d    = d;
    t.rdy  = 3'(rdy);
    t.er   = 1'(er);
    t.evo  = 3'(evo);
    t.elo  = 3'(elo);
    t.edo  = 24'(edo);
    t.eerr = 1'(eerr);
    t.elvl = 3'(elvl);
    tbl.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_pkt [4];
    int         n;
    int         got;
    int         cyc;

    rst_n   = 1'b0;
    valid_i = 1'b0;
    sel_i   = '0;
    data_i  = '0;
    ready_i = 3'b111;
    repeat (2) @(posedge clk_mst);

    // reset release, single word on ch1
    add(1,0,0,32'h0,7,         0,0,0,24'h000000,0,0);
    add(1,1,1,32'hDDCCBBAA,7,  1,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,1);
    add(1,0,0,32'h0,7,         1,2,0,24'h00AA00,0,0);
    add(1,0,0,32'h0,7,         1,2,0,24'h00BB00,0,0);
    add(1,0,0,32'h0,7,         1,2,0,24'h00CC00,0,0);
    add(1,0,0,32'h0,7,         1,2,2,24'h00DD00,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,0);
    // back-to-back ch0 then ch2
    add(1,1,0,32'h04030201,7,  1,0,0,24'h000000,0,0);
    add(1,1,2,32'h08070605,7,  1,0,0,24'h000000,0,1);
    add(1,0,0,32'h0,7,         1,1,0,24'h000001,0,1);
    add(1,0,0,32'h0,7,         1,1,0,24'h000002,0,1);
    add(1,0,0,32'h0,7,         1,1,0,24'h000003,0,1);
    add(1,0,0,32'h0,7,         1,1,1,24'h000004,0,1);
    add(1,0,0,32'h0,7,         1,4,0,24'h050000,0,0);
    add(1,0,0,32'h0,7,         1,4,0,24'h060000,0,0);
    add(1,0,0,32'h0,7,         1,4,0,24'h070000,0,0);
    add(1,0,0,32'h0,7,         1,4,4,24'h080000,0,0);
    // ch0 stalled during BB
    add(1,1,0,32'hDDCCBBAA,7,  1,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,1);
    add(1,0,0,32'h0,7,         1,1,0,24'h0000AA,0,0);
    add(1,0,0,32'h0,6,         1,1,0,24'h0000BB,0,0);
    add(1,0,0,32'h0,6,         1,1,0,24'h0000BB,0,0);
    add(1,0,0,32'h0,6,         1,1,0,24'h0000BB,0,0);
    add(1,0,0,32'h0,7,         1,1,0,24'h0000BB,0,0);
    add(1,0,0,32'h0,7,         1,1,0,24'h0000CC,0,0);
    add(1,0,0,32'h0,7,         1,1,1,24'h0000DD,0,0);
    // bad select discarded, then an all-zero word on ch1
    add(1,1,3,32'h11223344,7,  1,0,0,24'h000000,0,0);
    add(1,1,1,32'h00000000,7,  1,0,0,24'h000000,0,1);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,1,1);
    add(1,0,0,32'h0,7,         1,2,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,2,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,2,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,2,2,24'h000000,0,0);
    // fill with all ready_i low; sixth word held by the source
    add(1,1,0,32'h44332211,0,  1,0,0,24'h000000,0,0);
    add(1,1,1,32'h88776655,0,  1,0,0,24'h000000,0,1);
    add(1,1,2,32'hCCBBAA99,0,  1,1,0,24'h000011,0,1);
    add(1,1,0,32'h0D0C0B0A,0,  1,1,0,24'h000011,0,2);
    add(1,1,1,32'h1E1D1C1B,0,  1,1,0,24'h000011,0,3);
    add(1,1,2,32'hF0F0F0F0,0,  0,1,0,24'h000011,0,4);
    add(1,1,2,32'hF0F0F0F0,1,  0,1,0,24'h000011,0,4);
    add(1,1,2,32'hF0F0F0F0,1,  0,1,0,24'h000022,0,4);
    add(1,1,2,32'hF0F0F0F0,1,  0,1,0,24'h000033,0,4);
    add(1,1,2,32'hF0F0F0F0,1,  0,1,1,24'h000044,0,4);
    add(1,1,2,32'hF0F0F0F0,1,  1,2,0,24'h005500,0,3);
    // reset with full buffer and a word in flight
    add(0,0,0,32'h0,1,         0,2,0,24'h005500,0,4);
    add(1,0,0,32'h0,7,         0,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,0);
    // reset right after packet BB
    add(1,1,1,32'hDDCCBBAA,7,  1,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,1);
    add(1,0,0,32'h0,7,         1,2,0,24'h00AA00,0,0);
    add(0,0,0,32'h0,7,         1,2,0,24'h00BB00,0,0);
    add(1,0,0,32'h0,7,         0,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,0);
    add(1,1,2,32'h0A0B0C0D,7,  1,0,0,24'h000000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,1);
    add(1,0,0,32'h0,7,         1,4,0,24'h0D0000,0,0);
    add(1,0,0,32'h0,7,         1,4,0,24'h0C0000,0,0);
    add(1,0,0,32'h0,7,         1,4,0,24'h0B0000,0,0);
    add(1,0,0,32'h0,7,         1,4,4,24'h0A0000,0,0);
    add(1,0,0,32'h0,7,         1,0,0,24'h000000,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_mst);
      rst_n   = tbl[i].rst;
      valid_i = tbl[i].v;
      sel_i   = tbl[i].sel;
      data_i  = tbl[i].d;
      ready_i = tbl[i].rdy;
      total++;
      if ({ready_o, valid_o, last_o, data_o, err_o, level_o} ===
          {tbl[i].er, tbl[i].evo, tbl[i].elo, tbl[i].edo, tbl[i].eerr, tbl[i].elvl})
        passed++;
      else
        $display("FAIL row %0d: got ready=%b valid=%b last=%b data=%h err=%b level=%0d, want ready=%b valid=%b last=%b data=%h err=%b level=%0d",
                 i, ready_o, valid_o, last_o, data_o, err_o, level_o,
                 tbl[i].er, tbl[i].evo, tbl[i].elo, tbl[i].edo, tbl[i].eerr, tbl[i].elvl);
    end

    // ch0 word with ready_i[0] toggling every cycle
    exp_pkt[0] = 8'h69;
    exp_pkt[1] = 8'h7A;
    exp_pkt[2] = 8'h8B;
    exp_pkt[3] = 8'h9C;
    @(negedge clk_mst);
    valid_i = 1'b1;
    sel_i   = 2'd0;
    data_i  = 32'h9C8B7A69;
    n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk_mst);
      n++;
    end
    total++;
    if (ready_o) passed++;
    else $display("FAIL accept_wait: got ready_o=%b after %0d cycles, want 1", ready_o, n);

    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk_mst);
      valid_i = 1'b0;
      ready_i = {2'b11, cyc[0]};
      if (valid_o[0] && ready_i[0]) begin
        total++;
        if (data_o[7:0] === exp_pkt[got] && last_o[0] === (got == 3) &&
            valid_o[2:1] === 2'b00 && data_o[23:8] === 16'h0)
          passed++;
        else
          $display("FAIL toggle_pkt%0d: got data=%h valid=%b last=%b, want data=%h valid=001 last=%b",
                   got, data_o, valid_o, last_o, {16'h0, exp_pkt[got]}, 3'(got == 3));
        got++;
      end
      cyc++;
    end
    total++;
    if (got == 4) passed++;
    else $display("FAIL toggle_timeout: got %0d packets, want 4", got);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
